sramc_arbiter: RTL

- Two-port arbiter and sequencer placed in front of the sram8x8k bank array. It shares the SRAM between the AHB slave side (port A) and a secondary master such as a BIST or DMA engine (port B).
- Per cycle it picks at most one access, drives registered chip-select, write-enable, address and data to the SRAM banks, and returns read data to the winning port.
- The array is 2 groups × 4 byte lanes of 8-bit × 8k SRAM (8 chips total), giving a 32-bit word path.

---
 rtl/sramc_pkg.sv | 23 ++
 rtl/sramc_rr_arb.sv | 60 ++++++
 rtl/sramc_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/sramc_pkg.sv
// Shared types and default widths for the SRAM arbiter slice.
package sramc_pkg;

  localparam int unsigned SRAMC_SRAM_DW = 8;
  localparam int unsigned SRAMC_SRAM_AW = 13;
  localparam int unsigned SRAMC_DW      = 32;
  localparam int unsigned NUM_LANES     = SRAMC_DW / SRAMC_SRAM_DW;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

  typedef struct packed {
    logic                     we;
    logic [SRAMC_SRAM_AW:0]   addr;
    logic [NUM_LANES-1:0]     be;
    logic [SRAMC_DW-1:0]      wdata;
    logic                     lock;
  } sram_req_t;

endpackage

// File: rtl/sramc_rr_arb.sv
// Two-input round-robin arbiter with lock ownership bounded by a hold counter.
module sramc_rr_arb
  import sramc_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

  owner_t     owner;
  owner_t     last_winner;
  owner_t     win_own;
  logic       locked;
  logic       hold_ok;
  logic [3:0] hold_cnt;

  always_comb begin
    gnt     = '0;
    hold_ok = locked && (owner != OWN_NONE) && (hold_cnt < HOLD_LIM);
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (hold_ok) gnt = (owner == OWN_A) ? 2'b01 : 2'b10;
          else         gnt = (last_winner == OWN_A) ? 2'b10 : 2'b01;
        end
        default: gnt = '0;
      endcase
    end
    win_own = gnt[1] ? OWN_B : OWN_A;
  end

  // The counter only advances while the other port is kept waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_NONE;
      last_winner <= OWN_B;
      locked      <= 1'b0;
      hold_cnt    <= '0;
    end else if (req == 2'b00) begin
      owner    <= OWN_NONE;
      locked   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      owner       <= win_own;
      last_winner <= win_own;
      locked      <= gnt[1] ? lock[1] : lock[0];
      if (win_own != owner) hold_cnt <= '0;
      else if (&req)        hold_cnt <= hold_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/sramc_arbiter.sv
// Two-port arbiter/sequencer in front of the 2x4 byte-lane SRAM array:
// accept at T, registered SRAM launch at T+1, read return at T+2.
module sramc_arbiter
  import sramc_pkg::*;
#(
  parameter int unsigned SRAM_DATA_WIDTH = SRAMC_SRAM_DW,
  parameter int unsigned SRAM_ADDR_WIDTH = SRAMC_SRAM_AW,
  parameter int unsigned DATA_WIDTH      = SRAMC_DW,
  parameter int unsigned MAX_HOLD        = 16,
  localparam int unsigned LANES          = DATA_WIDTH / SRAM_DATA_WIDTH
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic                       a_req,
  input  logic                       a_we,
  input  logic [SRAM_ADDR_WIDTH:0]   a_addr,
  input  logic [LANES-1:0]           a_be,
  input  logic [DATA_WIDTH-1:0]      a_wdata,
  input  logic                       a_lock,
  output logic                       a_gnt,
  output logic                       a_rvalid,
  output logic [DATA_WIDTH-1:0]      a_rdata,
  input  logic                       b_req,
  input  logic                       b_we,
  input  logic [SRAM_ADDR_WIDTH:0]   b_addr,
  input  logic [LANES-1:0]           b_be,
  input  logic [DATA_WIDTH-1:0]      b_wdata,
  input  logic                       b_lock,
  output logic                       b_gnt,
  output logic                       b_rvalid,
  output logic [DATA_WIDTH-1:0]      b_rdata,
  output logic [2*LANES-1:0]         sram_csn,
  output logic                       sram_wen,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_wdata,
  input  logic [DATA_WIDTH-1:0]      sram_rdata0,
  input  logic [DATA_WIDTH-1:0]      sram_rdata1
);

  sram_req_t                  req_a, req_b;
  logic [1:0]                 gnt;
  logic                       accept;
  logic                       win_we;
  logic [SRAM_ADDR_WIDTH:0]   win_addr;
  logic [LANES-1:0]           win_be;
  logic [LANES-1:0]           lane_sel;
  logic [DATA_WIDTH-1:0]      win_wdata;
  logic [2*LANES-1:0]         csn_next;
  logic                       l_rd, l_port, l_group;
  logic                       r_valid, r_port, r_group;
  logic [DATA_WIDTH-1:0]      rd_sel;

  assign req_a = '{we: a_we, addr: a_addr, be: a_be, wdata: a_wdata, lock: a_lock};
  assign req_b = '{we: b_we, addr: b_addr, be: b_be, wdata: b_wdata, lock: b_lock};

  sramc_rr_arb #(.MAX_HOLD(MAX_HOLD)) u_arb (
    .clk  (hclk),
    .rst  (hreset),
    .req  ({b_req, a_req}),
    .lock ({req_b.lock, req_a.lock}),
    .gnt  (gnt)
  );

  assign a_gnt  = gnt[0];
  assign b_gnt  = gnt[1];
  assign accept = |gnt;

  // Reads enable every lane of the group; writes only the byte-enabled lanes.
  always_comb begin
    win_we    = gnt[1] ? req_b.we    : req_a.we;
    win_addr  = gnt[1] ? req_b.addr  : req_a.addr;
    win_be    = gnt[1] ? req_b.be    : req_a.be;
    win_wdata = gnt[1] ? req_b.wdata : req_a.wdata;
    lane_sel  = win_we ? win_be : '1;
    csn_next  = win_addr[SRAM_ADDR_WIDTH] ? {~lane_sel, {LANES{1'b1}}}
                                          : {{LANES{1'b1}}, ~lane_sel};
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      sram_csn   <= '1;
      sram_wen   <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      l_rd       <= 1'b0;
      l_port     <= 1'b0;
      l_group    <= 1'b0;
      r_valid    <= 1'b0;
      r_port     <= 1'b0;
      r_group    <= 1'b0;
    end else begin
      l_rd    <= accept & ~win_we;
      l_port  <= gnt[1];
      l_group <= win_addr[SRAM_ADDR_WIDTH];
      r_valid <= l_rd;
      r_port  <= l_port;
      r_group <= l_group;
      if (accept) begin
        sram_csn  <= csn_next;
        sram_wen  <= ~win_we;
        sram_addr <= win_addr[SRAM_ADDR_WIDTH-1:0];
        if (win_we) sram_wdata <= win_wdata;
      end else begin
        sram_csn <= '1;
        sram_wen <= 1'b1;
      end
    end
  end

  assign rd_sel   = r_group ? sram_rdata1 : sram_rdata0;
  assign a_rvalid = r_valid & ~r_port;
  assign b_rvalid = r_valid &  r_port;
  assign a_rdata  = a_rvalid ? rd_sel : '0;
  assign b_rdata  = b_rvalid ? rd_sel : '0;

endmodule
